// File: rtl/ram_sram_responder.sv
// ram_sram_responder: RAM_IF device that serves host requests from an external 8-bit async SRAM.
// Latency from the sampling edge to ACK_n low: refresh 1, write 3+WR_WAIT, read 1+2*RD_WAIT cycles.
// Backpressure: the host holds its strobe until ACK_n; a strobe still held after ACK parks the FSM in RELEASE.
module ram_sram_responder #(
  parameter int ADDR_BIT_WIDTH = 24,
  parameter int RD_WAIT        = 2,
  parameter int WR_WAIT        = 2
) (
  input  logic                      CLK,
  input  logic                      RESET_n,
  // RAM_IF device side
  input  logic [ADDR_BIT_WIDTH-1:0] ADDR,
  input  logic                      OE_n,
  input  logic                      WE_n,
  input  logic                      RFSH_n,
  input  logic [7:0]                DIN,
  output logic [15:0]               DOUT,
  output logic                      ACK_n,
  // SRAM side
  output logic [ADDR_BIT_WIDTH-1:0] SRAM_A,
  output logic                      SRAM_CE_n,
  output logic                      SRAM_OE_n,
  output logic                      SRAM_WE_n,
  output logic [7:0]                SRAM_D_OUT,
  output logic                      SRAM_D_OE,
  input  logic [7:0]                SRAM_D_IN
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD_LO    = 3'd1;
  localparam logic [2:0] RD_HI    = 3'd2;
  localparam logic [2:0] WR_SETUP = 3'd3;
  localparam logic [2:0] WR_PULSE = 3'd4;
  localparam logic [2:0] WR_HOLD  = 3'd5;
  localparam logic [2:0] ACK      = 3'd6;
  localparam logic [2:0] RELEASE  = 3'd7;

  localparam logic [1:0] KIND_RD = 2'd0;
  localparam logic [1:0] KIND_WR = 2'd1;
  localparam logic [1:0] KIND_RF = 2'd2;

  // Counter reload values: the counter counts down to zero, so N cycles loads N-1.
  localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WR_WAIT - 1);

  logic [2:0]                state;
  logic [2:0]                state_nxt;
  logic [3:0]                cnt;
  logic                      cnt_done;
  logic                      any_req;
  logic                      req_pend;
  logic [1:0]                kind_q;
  logic [ADDR_BIT_WIDTH-1:0] addr_q;
  logic [7:0]                din_q;
  logic [ADDR_BIT_WIDTH-1:0] addr_even;
  logic [ADDR_BIT_WIDTH-1:0] addr_odd;
  logic                      nxt_sram_cycle;
  logic                      nxt_read;
  logic                      nxt_write;

  assign any_req   = ~(OE_n & WE_n & RFSH_n);
  assign cnt_done  = (cnt == 4'd0);
  // Reads always fetch the aligned even/odd pair; bit0 of the request is dropped, no carry.
  assign addr_even = {addr_q[ADDR_BIT_WIDTH-1:1], 1'b0};
  assign addr_odd  = {addr_q[ADDR_BIT_WIDTH-1:1], 1'b1};

  // Latch the request on the sampling edge; later host changes to ADDR/DIN are ignored.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      req_pend <= 1'b0;
      kind_q   <= KIND_RF;
      addr_q   <= '0;
      din_q    <= 8'h00;
    end else if (state == IDLE) begin
      if (req_pend) begin
        req_pend <= 1'b0;
      end else if (any_req) begin
        req_pend <= 1'b1;
        addr_q   <= ADDR;
        din_q    <= DIN;
        // Write wins over read, read wins over refresh.
        if (!WE_n)      kind_q <= KIND_WR;
        else if (!OE_n) kind_q <= KIND_RD;
        else            kind_q <= KIND_RF;
      end
    end
  end

  // Next-state decode; every state entry is a real change of state, which reloads the counter.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_pend) begin
          case (kind_q)
            KIND_WR: state_nxt = WR_SETUP;
            KIND_RD: state_nxt = RD_LO;
            default: state_nxt = ACK;
          endcase
        end
      end
      RD_LO:    if (cnt_done) state_nxt = RD_HI;
      RD_HI:    if (cnt_done) state_nxt = ACK;
      WR_SETUP: state_nxt = WR_PULSE;
      WR_PULSE: if (cnt_done) state_nxt = WR_HOLD;
      WR_HOLD:  state_nxt = ACK;
      ACK:      state_nxt = RELEASE;
      RELEASE:  if (!any_req) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // State register and the per-state wait counter.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        case (state_nxt)
          RD_LO, RD_HI: cnt <= RD_LOAD;
          WR_PULSE:     cnt <= WR_LOAD;
          default:      cnt <= 4'd0;
        endcase
      end else if (!cnt_done) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Strobe classes of the state being entered, so the pins change on the same edge as the state.
  assign nxt_read       = (state_nxt == RD_LO) || (state_nxt == RD_HI);
  assign nxt_write      = (state_nxt == WR_SETUP) || (state_nxt == WR_PULSE) ||
                          (state_nxt == WR_HOLD);
  assign nxt_sram_cycle = nxt_read || nxt_write;

  // Registered SRAM pins; pad drive and output enable come from disjoint state groups.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      SRAM_A     <= '0;
      SRAM_CE_n  <= 1'b1;
      SRAM_OE_n  <= 1'b1;
      SRAM_WE_n  <= 1'b1;
      SRAM_D_OUT <= 8'h00;
      SRAM_D_OE  <= 1'b0;
    end else begin
      SRAM_CE_n <= ~nxt_sram_cycle;
      SRAM_OE_n <= ~nxt_read;
      SRAM_WE_n <= ~(state_nxt == WR_PULSE);
      SRAM_D_OE <= nxt_write;
      case (state_nxt)
        RD_LO:    SRAM_A <= addr_even;
        RD_HI:    SRAM_A <= addr_odd;
        WR_SETUP: SRAM_A <= addr_q;
        default:  SRAM_A <= SRAM_A;
      endcase
      if (state_nxt == WR_SETUP) begin
        SRAM_D_OUT <= din_q;
      end
    end
  end

  // Host-side results: one-cycle ACK pulse, read bytes captured on the closing edge of each byte window.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      ACK_n <= 1'b1;
      DOUT  <= 16'h0000;
    end else begin
      ACK_n <= ~(state_nxt == ACK);
      if ((state == RD_LO) && cnt_done) begin
        DOUT[7:0] <= SRAM_D_IN;
      end
      if ((state == RD_HI) && cnt_done) begin
        DOUT[15:8] <= SRAM_D_IN;
      end
    end
  end

endmodule
